tspp_memory_arbiter: RTL and testbench
======================================

Name: tspp_memory_arbiter

Overview:
- Shares the single memory master port between the fetch stage (instruction reads) and the execute stage (data reads/writes) of the two-stage pipeline.
- Generates the i_mem_busy and d_mem_busy indications consumed by the hazard unit.
- Data has priority by default. A starvation counter bounds fetch latency under data-heavy traffic.
- Sits between the fetch/execute stages and the memory-side bus adapter.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants allowed while an instruction request is pending; after that, fetch is granted. Must be ≥1.
- DATA_PRIORITY, 1: 1 = data wins simultaneous arbitration; 0 = instruction wins. The starvation rule applies to the non-priority side.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- i_ren  in  1  fetch read request
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch read data, valid when i_ren=1 and i_busy=0
- i_busy  out  1  fetch request not yet complete
- d_ren  in  1  data read request
- d_wen  in  1  data write request
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_byte_en  in  4  write byte enables
- d_rdata  out  32  data read data, valid when d_ren=1 and d_busy=0
- d_busy  out  1  data request not yet complete
- m_ren  out  1  memory read strobe
- m_wen  out  1  memory write strobe
- m_addr  out  32  memory address
- m_wdata  out  32  memory write data
- m_byte_en  out  4  memory byte enables (4'hF for reads)
- m_rdata  in  32  memory read data
- m_busy  in  1  memory busy; a transfer completes in the cycle m_busy=0 while a strobe is high

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, m_ren=m_wen=0, m_addr=m_wdata=0, m_byte_en=0, starve_cnt=0. i_busy and d_busy follow their request inputs (1 if the request is asserted, else 0). i_rdata and d_rdata follow m_rdata.
- FSM states: IDLE, GRANT_I, GRANT_D, DRAIN.
- Arbitration:
  - Evaluated in IDLE and in any completion cycle.
  - Pending requests: i_ren for fetch; d_ren|d_wen for data.
  - Winner selection: if one requester is pending, it wins. If both are pending, the DATA_PRIORITY side wins, unless starve_cnt==STARVE_LIMIT, in which case the other side wins.
  - The winner's address, wdata, byte_en and type are latched into the m_* registers at the clock edge. m_* are registered outputs.
- Latency:
  - From IDLE: one cycle of arbitration latency, then the strobe.
  - Minimum request-to-completion is 2 cycles with a zero-wait memory.
- Completion (GRANT_x with m_busy=0):
  - The granted requester's busy is 0 that cycle.
  - Its rdata passes through combinationally from m_rdata.
  - Next state comes from re-arbitration of the other requester or a new request: back-to-back transfers with no bubble. Otherwise the next state is IDLE and the strobes drop.
- Busy rule: x_busy = x_request AND NOT (state==GRANT_x AND m_busy==0).
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while i_ren=1.
  - Clears on any instruction grant, or at any arbitration where i_ren=0.
  - Width is $clog2(STARVE_LIMIT+1).
- Abort:
  - If the granted requester drops its request before completion, the FSM enters DRAIN.
  - In DRAIN, m_* are held unchanged until m_busy=0. No completion is reported and rdata is discarded.
  - Then the FSM arbitrates normally.
  - A re-asserted request during DRAIN waits for arbitration.
- Stability: m_* do not change while in GRANT_x or DRAIN. Requester input changes during a grant are ignored until completion.
- d_ren and d_wen both high: treated as a write. A simulation-only assertion fires.
- Reset mid-transfer: strobes go to 0 asynchronously and the transfer is abandoned. The memory side must tolerate this.

Decomposition:
- Package tspp_arb_pkg holds:
  - arb_state_t enum {IDLE, GRANT_I, GRANT_D, DRAIN}
  - req_id_t enum {REQ_I, REQ_D}
  - default constants for STARVE_LIMIT and DATA_PRIORITY
- word_t is taken from rv32i_types_pkg.
- One sub-module, tspp_arb_select: combinational winner pick from the pending bits, DATA_PRIORITY and starve_cnt==STARVE_LIMIT. Outputs grant_valid and req_id_t.

Test Plan:
1. Lone fetch, i_addr=0x200, memory 0-wait, m_rdata=0x00000013 -> m_ren=1 and m_addr=0x200 in cycle 1; i_busy=0 and i_rdata=0x13 in cycle 1; i_busy=1 in cycle 0.
2. Simultaneous i_ren and d_wen, d_addr=0x1000, d_wdata=0xDEADBEEF, d_byte_en=4'b0011, m_busy=1 for 2 cycles -> data served first with m_wen=1 and m_byte_en=0011; fetch granted back-to-back in the completion cycle with no IDLE bubble; i_busy stays 1 throughout the data transfer.
3. Continuous data requests plus a held i_ren, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant; starve_cnt returns to 0.
4. Abort: fetch granted, m_busy=1; i_ren dropped after 1 cycle; m_busy released 3 cycles later -> m_ren and m_addr held through DRAIN; no i_busy=0 completion; a pending d_ren is granted the cycle after the drain completes.
5. nRST asserted mid-GRANT_D -> m_wen=0 asynchronously, before the next CLK edge; state=IDLE; a new request after reset release completes normally.
6. d_ren and d_wen both 1 -> a write is issued (m_wen=1, m_ren=0) and the assertion fires.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Shared RV32I scalar types used across the two-stage pipeline.
package rv32i_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/tspp_arb_pkg.sv
// Types and defaults for the fetch/data memory arbiter.
package tspp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

  localparam int unsigned STARVE_LIMIT_DEF  = 4;
  localparam bit          DATA_PRIORITY_DEF = 1'b1;
  localparam logic [3:0]  BYTE_EN_ALL       = 4'hF;

  function automatic arb_state_t grant_state(req_id_t id);
    return (id == REQ_I) ? GRANT_I : GRANT_D;
  endfunction

endpackage

// File: rtl/tspp_arb_select.sv
// Combinational winner pick between the fetch and data requesters.
module tspp_arb_select
  import tspp_arb_pkg::*;
#(
  parameter bit DATA_PRIORITY = DATA_PRIORITY_DEF
) (
  input  logic    i_pend_i,
  input  logic    d_pend_i,
  input  logic    starved_i,
  output logic    grant_valid_o,
  output req_id_t grant_id_o
);

  localparam req_id_t PRI_ID = DATA_PRIORITY ? REQ_D : REQ_I;
  localparam req_id_t ALT_ID = DATA_PRIORITY ? REQ_I : REQ_D;

  always_comb begin
    grant_valid_o = i_pend_i | d_pend_i;
    if (i_pend_i && d_pend_i) begin
      // The non-priority side wins once it has waited the full limit.
      grant_id_o = starved_i ? ALT_ID : PRI_ID;
    end else if (i_pend_i) begin
      grant_id_o = REQ_I;
    end else begin
      grant_id_o = REQ_D;
    end
  end

endmodule

// File: rtl/tspp_memory_arbiter.sv
// Shares the single memory master port between fetch and execute, with
// data priority by default and a starvation bound on the losing side.
module tspp_memory_arbiter
  import tspp_arb_pkg::*;
  import rv32i_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT  = STARVE_LIMIT_DEF,  // must be >= 1
  parameter bit          DATA_PRIORITY = DATA_PRIORITY_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_ren,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_busy,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_busy,
  output logic        m_ren,
  output logic        m_wen,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_busy
);

  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam req_id_t     PRI_ID = DATA_PRIORITY ? REQ_D : REQ_I;

  arb_state_t       state_q;
  logic             m_ren_q, m_wen_q;
  word_t            m_addr_q, m_wdata_q;
  logic [3:0]       m_byte_en_q;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic    i_pend, d_pend, np_pend;
  logic    arb_en, abort, starved;
  logic    grant_valid;
  req_id_t grant_id;

  assign i_pend  = i_ren;
  assign d_pend  = d_ren | d_wen;
  assign np_pend = DATA_PRIORITY ? i_pend : d_pend;
  assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  // In any non-idle state, m_busy low ends the current transfer (completion
  // or drain), so that cycle re-arbitrates for a bubble-free handover.
  assign arb_en = (state_q == IDLE) || !m_busy;
  assign abort  = m_busy && (((state_q == GRANT_I) && !i_pend) ||
                             ((state_q == GRANT_D) && !d_pend));

  tspp_arb_select #(
    .DATA_PRIORITY (DATA_PRIORITY)
  ) u_select (
    .i_pend_i      (i_pend),
    .d_pend_i      (d_pend),
    .starved_i     (starved),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_en) begin
      if (!np_pend) begin
        starve_cnt_d = '0;
      end else if (grant_id == PRI_ID) begin
        starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      m_ren_q      <= 1'b0;
      m_wen_q      <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_byte_en_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if (arb_en) begin
        if (grant_valid) begin
          state_q <= grant_state(grant_id);
          if (grant_id == REQ_I) begin
            m_ren_q     <= 1'b1;
            m_wen_q     <= 1'b0;
            m_addr_q    <= i_addr;
            m_wdata_q   <= '0;
            m_byte_en_q <= BYTE_EN_ALL;
          end else begin
            // A simultaneous read and write request is issued as a write.
            m_ren_q     <= ~d_wen;
            m_wen_q     <= d_wen;
            m_addr_q    <= d_addr;
            m_wdata_q   <= d_wdata;
            m_byte_en_q <= d_wen ? d_byte_en : BYTE_EN_ALL;
          end
        end else begin
          state_q <= IDLE;
          m_ren_q <= 1'b0;
          m_wen_q <= 1'b0;
        end
      end else if (abort) begin
        state_q <= DRAIN;
      end
    end
  end

  assign m_ren     = m_ren_q;
  assign m_wen     = m_wen_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_byte_en = m_byte_en_q;

  assign i_busy  = i_pend && !((state_q == GRANT_I) && !m_busy);
  assign d_busy  = d_pend && !((state_q == GRANT_D) && !m_busy);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  rw_conflict_a : assert property (@(posedge CLK) disable iff (!nRST) !(d_ren && d_wen))
    else $warning("d_ren and d_wen both high; request handled as a write");

endmodule

// File: tb/tb_tspp_memory_arbiter.sv
// Scoreboarded bench for tspp_memory_arbiter with default parameters.
module tb_tspp_memory_arbiter;
  import tspp_arb_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        i_ren, d_ren, d_wen, m_busy;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_byte_en;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_busy, d_busy, m_ren, m_wen;
  logic [3:0]  m_byte_en;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  txn_t exp_q[$];
  txn_t got_e;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  tspp_memory_arbiter dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_ren     (i_ren),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_busy    (i_busy),
    .d_ren     (d_ren),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_byte_en (d_byte_en),
    .d_rdata   (d_rdata),
    .d_busy    (d_busy),
    .m_ren     (m_ren),
    .m_wen     (m_wen),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_byte_en (m_byte_en),
    .m_rdata   (m_rdata),
    .m_busy    (m_busy)
  );

  function automatic txn_t mk(logic ren, logic wen, logic [31:0] addr,
                              logic [31:0] wdata, logic [3:0] be);
    txn_t t;
    t.ren = ren; t.wen = wen; t.addr = addr; t.wdata = wdata; t.be = be;
    return t;
  endfunction

  // Every finished memory handshake must match the next expected transfer.
  always @(negedge CLK) begin
    if (nRST && (m_ren || m_wen) && !m_busy) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bus_txn: unexpected ren=%b wen=%b addr=%h", m_ren, m_wen, m_addr);
      end else begin
        got_e = exp_q.pop_front();
        if ({m_ren, m_wen, m_addr, m_byte_en} !== {got_e.ren, got_e.wen, got_e.addr, got_e.be} ||
            (got_e.wen && (m_wdata !== got_e.wdata))) begin
          miscompares++;
          $display("FAIL bus_txn: got ren=%b wen=%b addr=%h wdata=%h be=%h, need ren=%b wen=%b addr=%h wdata=%h be=%h",
                   m_ren, m_wen, m_addr, m_wdata, m_byte_en,
                   got_e.ren, got_e.wen, got_e.addr, got_e.wdata, got_e.be);
        end
      end
    end
  end

  task automatic test_reset();
    nRST = 1'b0; i_ren = 1'b1; d_ren = 1'b0; d_wen = 1'b0; m_busy = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_byte_en = '0; m_rdata = 32'h1234_5678;
    @(negedge CLK);
    vectors++;
    if ({m_ren, m_wen, m_addr, m_wdata, m_byte_en} !== 70'd0) begin
      miscompares++; $display("FAIL reset_outputs: got %b %b %h %h %h, need all zero", m_ren, m_wen, m_addr, m_wdata, m_byte_en);
    end
    vectors++;
    if (dut.state_q !== IDLE || dut.starve_cnt_q !== 3'd0) begin
      miscompares++; $display("FAIL reset_state: got state=%0d cnt=%0d, need 0 0", dut.state_q, dut.starve_cnt_q);
    end
    vectors++;
    if ({i_busy, d_busy, i_rdata, d_rdata} !== {1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678}) begin
      miscompares++; $display("FAIL reset_follow: got ib=%b db=%b ir=%h dr=%h, need 1 0 12345678 12345678", i_busy, d_busy, i_rdata, d_rdata);
    end
    i_ren = 1'b0;
    #2 nRST = 1'b1;
  endtask

  task automatic test_lone_fetch();
    @(posedge CLK); #1;
    i_ren = 1'b1; i_addr = 32'h200; m_busy = 1'b0; m_rdata = 32'h0000_0013;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h200, 32'h0, 4'hF));
    @(negedge CLK);
    vectors++;
    if ({i_busy, m_ren} !== 2'b10) begin
      miscompares++; $display("FAIL fetch_c0: got i_busy=%b m_ren=%b, need 1 0", i_busy, m_ren);
    end
    @(negedge CLK);
    vectors++;
    if ({m_ren, m_addr, i_busy, i_rdata} !== {1'b1, 32'h200, 1'b0, 32'h13}) begin
      miscompares++; $display("FAIL fetch_c1: got m_ren=%b addr=%h i_busy=%b rdata=%h, need 1 200 0 13", m_ren, m_addr, i_busy, i_rdata);
    end
    #1 i_ren = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({m_ren, m_wen} !== 2'b00 || dut.state_q !== IDLE) begin
      miscompares++; $display("FAIL fetch_idle: got ren=%b wen=%b state=%0d, need 0 0 IDLE", m_ren, m_wen, dut.state_q);
    end
  endtask

  task automatic test_priority_b2b();
    @(posedge CLK); #1;
    i_ren = 1'b1; i_addr = 32'h300;
    d_wen = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF; d_byte_en = 4'b0011;
    m_busy = 1'b1; m_rdata = 32'h0000_0093;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'b0011));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h300, 32'h0, 4'hF));
    @(negedge CLK);
    vectors++;
    if ({i_busy, d_busy, m_wen} !== 3'b110) begin
      miscompares++; $display("FAIL b2b_c0: got ib=%b db=%b wen=%b, need 1 1 0", i_busy, d_busy, m_wen);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge CLK);
      vectors++;
      if ({m_wen, m_ren, m_byte_en, m_addr, m_wdata, i_busy, d_busy} !==
          {1'b1, 1'b0, 4'b0011, 32'h1000, 32'hDEAD_BEEF, 1'b1, 1'b1}) begin
        miscompares++; $display("FAIL b2b_wait%0d: got wen=%b ren=%b be=%b addr=%h wd=%h ib=%b db=%b", c, m_wen, m_ren, m_byte_en, m_addr, m_wdata, i_busy, d_busy);
      end
    end
    @(posedge CLK); #1 m_busy = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({d_busy, i_busy, m_wen, dut.starve_cnt_q} !== {1'b0, 1'b1, 1'b1, 3'd1}) begin
      miscompares++; $display("FAIL b2b_dcomplete: got db=%b ib=%b wen=%b cnt=%0d, need 0 1 1 1", d_busy, i_busy, m_wen, dut.starve_cnt_q);
    end
    #1 d_wen = 1'b0;
    @(negedge CLK);
    vectors++;
    if (dut.state_q !== GRANT_I || {m_ren, m_wen, m_addr, m_byte_en, i_busy, i_rdata} !==
        {1'b1, 1'b0, 32'h300, 4'hF, 1'b0, 32'h93}) begin
      miscompares++; $display("FAIL b2b_fetch: got state=%0d ren=%b wen=%b addr=%h be=%h ib=%b ir=%h", dut.state_q, m_ren, m_wen, m_addr, m_byte_en, i_busy, i_rdata);
    end
    #1 i_ren = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_starvation();
    @(posedge CLK); #1;
    i_ren = 1'b1; i_addr = 32'h400; d_ren = 1'b1; d_addr = 32'h2000; m_busy = 1'b0; m_rdata = 32'h5555_0000;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(1'b1, 1'b0, 32'h2000 + 32'(4 * k), 32'h0, 4'hF));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0, 4'hF));
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      vectors++;
      if (dut.state_q !== GRANT_D || {m_addr, d_busy, i_busy, d_rdata, dut.starve_cnt_q} !==
          {32'h2000 + 32'(4 * k), 1'b0, 1'b1, 32'h5555_0000, 3'(k + 1)}) begin
        miscompares++; $display("FAIL starve_data%0d: got state=%0d addr=%h db=%b ib=%b cnt=%0d", k, dut.state_q, m_addr, d_busy, i_busy, dut.starve_cnt_q);
      end
      #1 d_addr = d_addr + 32'd4;
    end
    @(negedge CLK);
    vectors++;
    if (dut.state_q !== GRANT_I || {m_addr, i_busy, d_busy, dut.starve_cnt_q} !== {32'h400, 1'b0, 1'b1, 3'd0}) begin
      miscompares++; $display("FAIL starve_fetch: got state=%0d addr=%h ib=%b db=%b cnt=%0d, need GRANT_I 400 0 1 0", dut.state_q, m_addr, i_busy, d_busy, dut.starve_cnt_q);
    end
    #1 i_ren = 1'b0; d_ren = 1'b0;
    @(negedge CLK);
    vectors++;
    if (dut.state_q !== IDLE || {m_ren, dut.starve_cnt_q} !== {1'b0, 3'd0}) begin
      miscompares++; $display("FAIL starve_idle: got state=%0d ren=%b cnt=%0d", dut.state_q, m_ren, dut.starve_cnt_q);
    end
  endtask

  task automatic test_abort();
    @(posedge CLK); #1;
    i_ren = 1'b1; i_addr = 32'h500; m_busy = 1'b1; m_rdata = 32'h0BAD_0BAD;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h500, 32'h0, 4'hF));
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (dut.state_q !== GRANT_I || {m_ren, m_addr, i_busy} !== {1'b1, 32'h500, 1'b1}) begin
      miscompares++; $display("FAIL abort_grant: got state=%0d ren=%b addr=%h ib=%b", dut.state_q, m_ren, m_addr, i_busy);
    end
    #1 d_ren = 1'b1; d_addr = 32'h3000;
    exp_q.push_back(mk(1'b1, 1'b0, 32'h3000, 32'h0, 4'hF));
    @(negedge CLK);
    #1 i_ren = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      if (c == 5) begin
        @(posedge CLK); #1 m_busy = 1'b0;
      end
      @(negedge CLK);
      vectors++;
      if (dut.state_q !== DRAIN || {m_ren, m_wen, m_addr, i_busy, d_busy} !== {1'b1, 1'b0, 32'h500, 1'b0, 1'b1}) begin
        miscompares++; $display("FAIL abort_drain_c%0d: got state=%0d ren=%b wen=%b addr=%h ib=%b db=%b", c, dut.state_q, m_ren, m_wen, m_addr, i_busy, d_busy);
      end
    end
    @(negedge CLK);
    vectors++;
    if (dut.state_q !== GRANT_D || {m_ren, m_addr, d_busy, d_rdata} !== {1'b1, 32'h3000, 1'b0, 32'h0BAD_0BAD}) begin
      miscompares++; $display("FAIL abort_next: got state=%0d ren=%b addr=%h db=%b dr=%h", dut.state_q, m_ren, m_addr, d_busy, d_rdata);
    end
    #1 d_ren = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    @(posedge CLK); #1;
    d_wen = 1'b1; d_addr = 32'h1100; d_wdata = 32'hCAFE_F00D; d_byte_en = 4'hF; m_busy = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (dut.state_q !== GRANT_D || m_wen !== 1'b1) begin
      miscompares++; $display("FAIL rstmid_grant: got state=%0d wen=%b, need GRANT_D 1", dut.state_q, m_wen);
    end
    #1 nRST = 1'b0;
    #1;
    vectors++;
    if (dut.state_q !== IDLE || {m_wen, m_ren, m_addr} !== {1'b0, 1'b0, 32'h0}) begin
      miscompares++; $display("FAIL rstmid_async: got state=%0d wen=%b ren=%b addr=%h, need IDLE 0 0 0", dut.state_q, m_wen, m_ren, m_addr);
    end
    d_wen = 1'b0; m_busy = 1'b0;
    @(negedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;
    d_wen = 1'b1; d_addr = 32'h1200; d_wdata = 32'h1234_5678; d_byte_en = 4'b1100;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h1200, 32'h1234_5678, 4'b1100));
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if ({m_wen, m_ren, m_addr, m_wdata, m_byte_en, d_busy} !== {1'b1, 1'b0, 32'h1200, 32'h1234_5678, 4'b1100, 1'b0}) begin
      miscompares++; $display("FAIL rstmid_after: got wen=%b ren=%b addr=%h wd=%h be=%b db=%b", m_wen, m_ren, m_addr, m_wdata, m_byte_en, d_busy);
    end
    #1 d_wen = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_rw_both();
    @(posedge CLK); #1;
    d_ren = 1'b1; d_wen = 1'b1; d_addr = 32'h1300; d_wdata = 32'hA5A5_A5A5; d_byte_en = 4'b0101; m_busy = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 32'h1300, 32'hA5A5_A5A5, 4'b0101));
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if ({m_wen, m_ren, m_byte_en, d_busy} !== {1'b1, 1'b0, 4'b0101, 1'b0}) begin
      miscompares++; $display("FAIL rw_both: got wen=%b ren=%b be=%b db=%b, need 1 0 0101 0", m_wen, m_ren, m_byte_en, d_busy);
    end
    #1 d_ren = 1'b0; d_wen = 1'b0;
    @(negedge CLK);
    vectors++;
    if ({m_wen, m_ren} !== 2'b00) begin
      miscompares++; $display("FAIL rw_idle: got wen=%b ren=%b, need 0 0", m_wen, m_ren);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_priority_b2b();
    test_starvation();
    test_abort();
    test_reset_mid();
    test_rw_both();
    @(negedge CLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL scoreboard_drain: %0d expected transfers never completed, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "timeout");
  end

endmodule
